uart_tx_arbiter: RTL and testbench

- Shares the single UART transmitter between NUM_REQ byte-stream requesters, e.g. the donut frame renderer and the banner/status ROM streamer.
- Round-robin arbitration at packet granularity: a granted requester holds the UART until it marks the last byte of its packet.
- Two watchdogs force release: an idle-timeout and a maximum packet length.
- Sits between the requesters and UART_Transmitter; drives its start/data_in and consumes its txe.

---
 rtl/uart_pkg.sv | 15 +
 rtl/rr_pick.sv | 35 +++
 rtl/uart_tx_arbiter.sv | 160 ++++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared types and constants for the UART transmit arbiter
package uart_pkg;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } state_t;

    // Line terminators requesters commonly use to mark the last byte of a packet
    localparam logic [7:0] ASCII_LF = 8'h0A;
    localparam logic [7:0] ASCII_CR = 8'h0D;

    localparam int DEFAULT_NUM_REQ = 2;

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational round-robin selector starting after last_ptr
module rr_pick #(
    parameter int N  = 2,
    parameter int IW = 1
) (
    input  logic [N-1:0]  valid,
    input  logic [IW-1:0] last_ptr,
    output logic [N-1:0]  winner,
    output logic [IW-1:0] winner_idx
);

    logic found;

    // First pass covers indices above last_ptr, second pass wraps to 0..last_ptr
    always_comb begin
        winner     = '0;
        winner_idx = '0;
        found      = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (!found && valid[i] && (i > int'(last_ptr))) begin
                found      = 1'b1;
                winner[i]  = 1'b1;
                winner_idx = IW'(i);
            end
        end
        for (int i = 0; i < N; i++) begin
            if (!found && valid[i] && (i <= int'(last_ptr))) begin
                found      = 1'b1;
                winner[i]  = 1'b1;
                winner_idx = IW'(i);
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - packet-granular round-robin sharing of one UART transmitter
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int NUM_REQ      = DEFAULT_NUM_REQ,
    parameter int IDLE_TIMEOUT = 1024,
    parameter int MAX_PKT      = 256
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_REQ-1:0]   req_valid,
    input  logic [8*NUM_REQ-1:0] req_data,
    input  logic [NUM_REQ-1:0]   req_last,
    output logic [NUM_REQ-1:0]   req_ready,
    output logic                 uart_start,
    output logic [7:0]           uart_data,
    input  logic                 uart_txe,
    output logic [NUM_REQ-1:0]   grant,
    output logic                 busy,
    output logic                 abort
);

    localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int BW = (MAX_PKT > 0) ? $clog2(MAX_PKT + 1) : 1;
    localparam int TW = (IDLE_TIMEOUT > 0) ? $clog2(IDLE_TIMEOUT + 1) : 1;

    localparam logic [BW-1:0] PKT_LIMIT = BW'(MAX_PKT);
    localparam logic [TW-1:0] IDLE_LAST = TW'((IDLE_TIMEOUT > 0) ? IDLE_TIMEOUT - 1 : 0);

    state_t               state_q, state_d;
    logic [NUM_REQ-1:0]   grant_q, grant_d;
    logic [IW-1:0]        gidx_q, gidx_d;
    logic [IW-1:0]        last_ptr_q, last_ptr_d;
    logic [7:0]           hold_data_q, hold_data_d;
    logic                 hold_full_q, hold_full_d;
    logic                 hold_last_q, hold_last_d;
    logic [BW-1:0]        byte_cnt_q, byte_cnt_d;
    logic [TW-1:0]        idle_cnt_q, idle_cnt_d;
    logic                 abort_q, abort_d;

    logic [NUM_REQ-1:0]   pick_onehot;
    logic [IW-1:0]        pick_idx;
    logic                 own_valid;
    logic                 own_last;
    logic [7:0]           own_data;

    rr_pick #(
        .N  (NUM_REQ),
        .IW (IW)
    ) u_pick (
        .valid      (req_valid),
        .last_ptr   (last_ptr_q),
        .winner     (pick_onehot),
        .winner_idx (pick_idx)
    );

    // Route the current owner's stream through a one-hot mux on the grant
    always_comb begin
        own_valid = 1'b0;
        own_last  = 1'b0;
        own_data  = 8'h00;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_q[i]) begin
                own_valid = req_valid[i];
                own_last  = req_last[i];
                own_data  = req_data[8*i +: 8];
            end
        end
    end

    // Arbitration, holding register load/drain, release and watchdog decisions
    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        gidx_d      = gidx_q;
        last_ptr_d  = last_ptr_q;
        hold_data_d = hold_data_q;
        hold_full_d = hold_full_q;
        hold_last_d = hold_last_q;
        byte_cnt_d  = byte_cnt_q;
        idle_cnt_d  = idle_cnt_q;
        abort_d     = 1'b0;

        if (state_q == ST_IDLE) begin
            if (|req_valid) begin
                grant_d = pick_onehot;
                gidx_d  = pick_idx;
                state_d = ST_LOCKED;
            end
        end else begin
            if (!hold_full_q && own_valid) begin
                hold_data_d = own_data;
                hold_last_d = own_last;
                hold_full_d = 1'b1;
                idle_cnt_d  = '0;
                if (byte_cnt_q != '1) begin
                    byte_cnt_d = byte_cnt_q + BW'(1);
                end
            end else if (hold_full_q && uart_txe) begin
                hold_full_d = 1'b0;
                if (hold_last_q || ((MAX_PKT != 0) && (byte_cnt_q == PKT_LIMIT))) begin
                    state_d     = ST_IDLE;
                    last_ptr_d  = gidx_q;
                    grant_d     = '0;
                    byte_cnt_d  = '0;
                    idle_cnt_d  = '0;
                    hold_last_d = 1'b0;
                end
            end else if (!hold_full_q && !own_valid) begin
                // Owner has gone quiet with nothing buffered: run the idle watchdog
                if ((IDLE_TIMEOUT != 0) && (idle_cnt_q == IDLE_LAST)) begin
                    state_d     = ST_IDLE;
                    last_ptr_d  = gidx_q;
                    grant_d     = '0;
                    byte_cnt_d  = '0;
                    idle_cnt_d  = '0;
                    hold_last_d = 1'b0;
                    abort_d     = 1'b1;
                end else if (idle_cnt_q != '1) begin
                    idle_cnt_d = idle_cnt_q + TW'(1);
                end
            end
        end
    end

    // State register with synchronous active-high reset; requester 0 wins first
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            grant_q     <= '0;
            gidx_q      <= '0;
            last_ptr_q  <= IW'(NUM_REQ - 1);
            hold_data_q <= 8'h00;
            hold_full_q <= 1'b0;
            hold_last_q <= 1'b0;
            byte_cnt_q  <= '0;
            idle_cnt_q  <= '0;
            abort_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            gidx_q      <= gidx_d;
            last_ptr_q  <= last_ptr_d;
            hold_data_q <= hold_data_d;
            hold_full_q <= hold_full_d;
            hold_last_q <= hold_last_d;
            byte_cnt_q  <= byte_cnt_d;
            idle_cnt_q  <= idle_cnt_d;
            abort_q     <= abort_d;
        end
    end

    assign grant      = grant_q;
    assign busy       = (state_q == ST_LOCKED);
    assign uart_start = hold_full_q;
    assign uart_data  = hold_data_q;
    assign abort      = abort_q;
    assign req_ready  = (busy && !hold_full_q) ? grant_q : '0;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb/tb_uart_tx_arbiter.sv - scoreboard bench for the UART transmit arbiter
module tb_uart_tx_arbiter;
    import uart_pkg::*;

    typedef struct packed {
        logic [1:0] grant;
        logic [7:0] data;
        logic       rel;
    } exp_t;

    logic        clk;
    logic        rst;
    logic [1:0]  req_valid;
    logic [15:0] req_data;
    logic [1:0]  req_last;
    logic [1:0]  req_ready;
    logic        uart_start;
    logic [7:0]  uart_data;
    logic        uart_txe;
    logic [1:0]  grant;
    logic        busy;
    logic        abort;

    uart_tx_arbiter #(
        .NUM_REQ      (2),
        .IDLE_TIMEOUT (16),
        .MAX_PKT      (4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_data   (req_data),
        .req_last   (req_last),
        .req_ready  (req_ready),
        .uart_start (uart_start),
        .uart_data  (uart_data),
        .uart_txe   (uart_txe),
        .grant      (grant),
        .busy       (busy),
        .abort      (abort)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int         n_total;
    int         n_pass;
    int         cyc;
    int         abort_cnt;
    int         abort_cyc;
    int         consume_cyc;
    int         txe_period;
    int         txe_cnt;
    logic       txe_hold;
    logic [8:0] src0_q[$];
    logic [8:0] src1_q[$];
    exp_t       exp_q[$];
    logic [1:0] pend_fire;
    logic       pend_consume;
    logic [7:0] cap_data;
    logic [1:0] cap_grant;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    endtask

    task automatic exp_push(input logic [1:0] g, input logic [7:0] d, input logic rel);
        exp_t e;
        e.grant = g;
        e.data  = d;
        e.rel   = rel;
        exp_q.push_back(e);
    endtask

    // One cycle: score last edge's transfers, then drive requesters and UART for the next edge
    task automatic tick();
        exp_t e;
        @(negedge clk);
        cyc++;
        if (abort) begin
            abort_cnt++;
            abort_cyc = cyc;
        end
        if (pend_consume) begin
            if (exp_q.size() == 0) begin
                check("extra_byte", 32'(cap_data), 32'hFFFF_FFFF);
            end else begin
                e = exp_q.pop_front();
                check("uart_data", 32'(cap_data), 32'(e.data));
                check("grant_on_byte", 32'(cap_grant), 32'(e.grant));
                check("busy_after_byte", 32'(busy), 32'(!e.rel));
                consume_cyc = cyc;
            end
        end
        if (pend_fire[0] && src0_q.size() > 0) src0_q.delete(0);
        if (pend_fire[1] && src1_q.size() > 0) src1_q.delete(0);
        req_valid[0] = (src0_q.size() > 0);
        req_valid[1] = (src1_q.size() > 0);
        {req_last[0], req_data[7:0]}  = req_valid[0] ? src0_q[0] : 9'h000;
        {req_last[1], req_data[15:8]} = req_valid[1] ? src1_q[0] : 9'h000;
        txe_cnt  = (txe_cnt + 1) % txe_period;
        uart_txe = !txe_hold && (txe_cnt == txe_period - 1);
        pend_fire    = rst ? 2'b00 : (req_valid & req_ready);
        pend_consume = !rst && uart_start && uart_txe;
        cap_data     = uart_data;
        cap_grant    = grant;
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        src0_q.delete();
        src1_q.delete();
        exp_q.delete();
        pend_fire    = 2'b00;
        pend_consume = 1'b0;
        for (int i = 0; i < n; i++) tick();
        rst       = 1'b0;
        abort_cnt = 0;
    endtask

    task automatic wait_drain(input string tag, input int budget);
        int n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            tick();
            n++;
        end
        check(tag, exp_q.size(), 0);
    endtask

    task automatic wait_start(input string tag, input int budget);
        int n = 0;
        while (!uart_start && n < budget) begin
            tick();
            n++;
        end
        check(tag, 32'(uart_start), 32'd1);
    endtask

    initial begin
        int n;
        int stable;
        n_total = 0; n_pass = 0; cyc = 0; abort_cnt = 0; abort_cyc = 0; consume_cyc = 0;
        rst = 1'b1; req_valid = '0; req_data = '0; req_last = '0; uart_txe = 1'b0;
        txe_hold = 1'b0; txe_period = 1; txe_cnt = 0;
        pend_fire = '0; pend_consume = 1'b0; cap_data = '0; cap_grant = '0;

        // Reset state
        do_reset(2);
        check("rst_grant", 32'(grant), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_uart_start", 32'(uart_start), 0);
        check("rst_uart_data", 32'(uart_data), 0);
        check("rst_req_ready", 32'(req_ready), 0);
        check("rst_abort", 32'(abort), 0);

        // Single requester sends "Hi\r\n", UART ready one cycle in ten
        txe_period = 10;
        src0_q.push_back({1'b0, 8'h48});
        src0_q.push_back({1'b0, 8'h69});
        src0_q.push_back({1'b0, ASCII_CR});
        src0_q.push_back({1'b1, ASCII_LF});
        exp_push(2'b01, 8'h48, 1'b0);
        exp_push(2'b01, 8'h69, 1'b0);
        exp_push(2'b01, 8'h0D, 1'b0);
        exp_push(2'b01, 8'h0A, 1'b1);
        wait_drain("single_drain", 300);
        check("single_grant_end", 32'(grant), 0);

        // Contention: whole packets alternate 0,1,0 with no interleaving
        do_reset(1);
        txe_period = 3;
        src0_q.push_back({1'b0, 8'h10}); src0_q.push_back({1'b0, 8'h11}); src0_q.push_back({1'b1, 8'h12});
        src0_q.push_back({1'b0, 8'h20}); src0_q.push_back({1'b0, 8'h21}); src0_q.push_back({1'b1, 8'h22});
        src1_q.push_back({1'b0, 8'h30}); src1_q.push_back({1'b0, 8'h31}); src1_q.push_back({1'b1, 8'h32});
        exp_push(2'b01, 8'h10, 1'b0); exp_push(2'b01, 8'h11, 1'b0); exp_push(2'b01, 8'h12, 1'b1);
        exp_push(2'b10, 8'h30, 1'b0); exp_push(2'b10, 8'h31, 1'b0); exp_push(2'b10, 8'h32, 1'b1);
        exp_push(2'b01, 8'h20, 1'b0); exp_push(2'b01, 8'h21, 1'b0); exp_push(2'b01, 8'h22, 1'b1);
        wait_drain("contend_drain", 300);

        // Back-pressure with a byte held, then idle timeout hands over to pending req1
        do_reset(1);
        txe_period = 1;
        txe_hold   = 1'b1;
        src0_q.push_back({1'b0, 8'hA5});
        exp_push(2'b01, 8'hA5, 1'b0);
        wait_start("bp_start", 20);
        check("bp_held_data", 32'(uart_data), 32'h0000_00A5);
        src1_q.push_back({1'b0, 8'h31});
        src1_q.push_back({1'b1, 8'h32});
        exp_push(2'b10, 8'h31, 1'b0);
        exp_push(2'b10, 8'h32, 1'b1);
        stable = 0;
        for (int i = 0; i < 50; i++) begin
            tick();
            if (uart_start && uart_data == 8'hA5 && req_ready == 2'b00 && grant == 2'b01) stable++;
        end
        check("bp_stable_cycles", stable, 50);
        check("bp_no_abort", abort_cnt, 0);
        txe_hold = 1'b0;
        n = 0;
        while (abort_cnt == 0 && n < 100) begin
            tick();
            n++;
        end
        check("abort_seen", abort_cnt, 1);
        check("abort_delay", abort_cyc - consume_cyc, 16);
        wait_drain("timeout_drain", 100);
        check("abort_once", abort_cnt, 1);

        // MAX_PKT=4 splits req1's 6-byte packet around req0's packet
        do_reset(1);
        txe_period = 4;
        for (int i = 1; i <= 6; i++) src1_q.push_back({(i == 6), 8'(8'h60 + i)});
        exp_push(2'b10, 8'h61, 1'b0); exp_push(2'b10, 8'h62, 1'b0);
        exp_push(2'b10, 8'h63, 1'b0); exp_push(2'b10, 8'h64, 1'b1);
        exp_push(2'b01, 8'h71, 1'b0); exp_push(2'b01, 8'h72, 1'b1);
        exp_push(2'b10, 8'h65, 1'b0); exp_push(2'b10, 8'h66, 1'b1);
        n = 0;
        while (grant != 2'b10 && n < 20) begin
            tick();
            n++;
        end
        check("maxpkt_first_grant", 32'(grant), 32'd2);
        src0_q.push_back({1'b0, 8'h71});
        src0_q.push_back({1'b1, 8'h72});
        wait_drain("maxpkt_drain", 400);
        check("maxpkt_no_abort", abort_cnt, 0);

        // One-cycle reset while a byte is held drops it and restores req0 priority
        do_reset(1);
        txe_hold = 1'b1;
        src0_q.push_back({1'b0, 8'h41});
        src0_q.push_back({1'b0, 8'h42});
        src0_q.push_back({1'b1, 8'h43});
        wait_start("mid_start", 20);
        check("mid_held_data", 32'(uart_data), 32'h0000_0041);
        do_reset(1);
        check("mid_rst_uart_start", 32'(uart_start), 0);
        check("mid_rst_grant", 32'(grant), 0);
        check("mid_rst_busy", 32'(busy), 0);
        check("mid_rst_ready", 32'(req_ready), 0);
        txe_hold   = 1'b0;
        txe_period = 2;
        src1_q.push_back({1'b1, 8'h66});
        src0_q.push_back({1'b1, 8'h55});
        exp_push(2'b01, 8'h55, 1'b1);
        exp_push(2'b10, 8'h66, 1'b1);
        wait_drain("mid_after_drain", 100);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
